fetch_stall_sequencer: RTL and testbench

// Fetch-side consumer of the hazard unit's PC_WriteEn / IFID_WriteEn / Stall_flush.

---
 rtl/fetch_stall_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_fetch_stall_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stall_sequencer.sv
// Fetch-side sequencer: owns the PC and the IF/ID register, fetches over a req/ack port
// and applies hazard-unit stalls, branch redirects and the END halt.
module fetch_stall_sequencer #(
    parameter int unsigned     PC_W    = 16,
    parameter int unsigned     INSTR_W = 16,
    parameter int unsigned     OP_LSB  = 13,
    parameter logic [PC_W-1:0] PC_INC  = {{(PC_W-1){1'b0}}, 1'b1},
    parameter logic [PC_W-1:0] PC_RST  = {PC_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PC_WriteEn,
    input  logic               IFID_WriteEn,
    input  logic               Stall_flush,
    input  logic               Branch_Taken,
    input  logic [PC_W-1:0]    Branch_Target,
    input  logic               IMem_Ack,
    input  logic [INSTR_W-1:0] IMem_Data,
    output logic               IMem_Req,
    output logic [PC_W-1:0]    IMem_Addr,
    output logic [INSTR_W-1:0] IFID_Instr,
    output logic [PC_W-1:0]    IFID_PC,
    output logic               IFID_Valid,
    output logic               IDEX_Bubble,
    output logic               Halted,
    output logic [15:0]        StallCount
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetchState_t;

    localparam logic [2:0] OP_END = 3'b111;

    function automatic logic [15:0] satInc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

    function automatic logic [2:0] opcodeOf(input logic [INSTR_W-1:0] instr);
        return instr[OP_LSB +: 3];
    endfunction

    fetchState_t        state_r;
    fetchState_t        nextState_s;
    logic [PC_W-1:0]    pc_r;
    logic [PC_W-1:0]    pcNext_s;
    logic [INSTR_W-1:0] bufInstr_r;
    logic [INSTR_W-1:0] bufInstrNext_s;
    logic               bufValid_r;
    logic               bufValidNext_s;
    logic [INSTR_W-1:0] ifidInstrNext_s;
    logic [PC_W-1:0]    ifidPcNext_s;
    logic               ifidValidNext_s;
    logic               reqNext_s;
    logic [PC_W-1:0]    addrNext_s;
    logic               bubbleNext_s;
    logic [15:0]        stallCountNext_s;
    logic               ackValid_s;
    logic               advance_s;
    logic               outstanding_s;
    logic               endInIfid_s;

    // An Ack only counts while our own request is on the bus, so a stale Ack after reset is dropped.
    assign ackValid_s    = IMem_Ack & IMem_Req;
    assign outstanding_s = IMem_Req & ~IMem_Ack;
    assign advance_s     = PC_WriteEn & IFID_WriteEn;
    assign endInIfid_s   = IFID_Valid & (opcodeOf(IFID_Instr) == OP_END);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state, next-PC and next-output computation.
    always_comb begin
        nextState_s     = state_r;
        pcNext_s        = pc_r;
        bufInstrNext_s  = bufInstr_r;
        bufValidNext_s  = bufValid_r;
        ifidInstrNext_s = IFID_Instr;
        ifidPcNext_s    = IFID_PC;
        ifidValidNext_s = IFID_Valid;

        if (state_r == HALT) begin
            nextState_s = HALT;
        end else if (Branch_Taken) begin
            // Redirect beats stall and HOLD; a same-cycle Ack belongs to the wrong path.
            pcNext_s        = Branch_Target;
            ifidValidNext_s = 1'b0;
            bufValidNext_s  = 1'b0;
            nextState_s     = outstanding_s ? DRAIN : FETCH;
        end else if (endInIfid_s) begin
            nextState_s = HALT;
        end else begin
            case (state_r)
                FETCH: begin
                    if (ackValid_s && advance_s) begin
                        ifidInstrNext_s = IMem_Data;
                        ifidPcNext_s    = pc_r;
                        ifidValidNext_s = 1'b1;
                        pcNext_s        = pc_r + PC_INC;
                    end else if (ackValid_s) begin
                        bufInstrNext_s = IMem_Data;
                        bufValidNext_s = 1'b1;
                        nextState_s    = HOLD;
                    end else if (IFID_WriteEn) begin
                        ifidValidNext_s = 1'b0;
                    end else begin
                        ifidValidNext_s = IFID_Valid;
                    end
                end
                HOLD: begin
                    if (advance_s) begin
                        ifidInstrNext_s = bufInstr_r;
                        ifidPcNext_s    = pc_r;
                        ifidValidNext_s = bufValid_r;
                        bufValidNext_s  = 1'b0;
                        pcNext_s        = pc_r + PC_INC;
                        nextState_s     = FETCH;
                    end else begin
                        nextState_s = HOLD;
                    end
                end
                DRAIN: begin
                    if (ackValid_s) begin
                        nextState_s = FETCH;
                    end else begin
                        nextState_s = DRAIN;
                    end
                end
                default: begin
                    nextState_s = FETCH;
                end
            endcase
        end

        // DRAIN keeps the abandoned address on the bus until its Ack is absorbed.
        reqNext_s = (nextState_s == FETCH) || (nextState_s == DRAIN);
        if (nextState_s == DRAIN) begin
            addrNext_s = IMem_Addr;
        end else begin
            addrNext_s = pcNext_s;
        end

        bubbleNext_s = Stall_flush | Branch_Taken | ~IFID_Valid;
        if (Stall_flush) begin
            stallCountNext_s = satInc16(StallCount);
        end else begin
            stallCountNext_s = StallCount;
        end
    end

    // PC, buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r        <= PC_RST;
            bufInstr_r  <= {INSTR_W{1'b0}};
            bufValid_r  <= 1'b0;
            IMem_Req    <= 1'b0;
            IMem_Addr   <= PC_RST;
            IFID_Instr  <= {INSTR_W{1'b0}};
            IFID_PC     <= {PC_W{1'b0}};
            IFID_Valid  <= 1'b0;
            IDEX_Bubble <= 1'b1;
            Halted      <= 1'b0;
            StallCount  <= 16'd0;
        end else begin
            pc_r        <= pcNext_s;
            bufInstr_r  <= bufInstrNext_s;
            bufValid_r  <= bufValidNext_s;
            IMem_Req    <= reqNext_s;
            IMem_Addr   <= addrNext_s;
            IFID_Instr  <= ifidInstrNext_s;
            IFID_PC     <= ifidPcNext_s;
            IFID_Valid  <= ifidValidNext_s;
            IDEX_Bubble <= bubbleNext_s;
            Halted      <= (nextState_s == HALT);
            StallCount  <= stallCountNext_s;
        end
    end

endmodule

// File: tb/tb_fetch_stall_sequencer.sv
// Bench for fetch_stall_sequencer: per-cycle vector table through an expected-output
// queue, then stall-counter saturation and PC wrap sequences.
module tb_fetch_stall_sequencer;

    typedef struct packed {
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] pc;
        logic [15:0] instr;
        logic        bubble;
        logic        halted;
        logic [15:0] stall;
    } outs_t;

    typedef struct packed {
        logic        rstN;
        logic        pcWe;
        logic        ifidWe;
        logic        sf;
        logic        br;
        logic [15:0] tgt;
        logic        ack;
        outs_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PC_WriteEn = 1'b0;
    logic        IFID_WriteEn = 1'b0;
    logic        Stall_flush = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [15:0] Branch_Target = 16'h0000;
    logic        IMem_Ack = 1'b0;
    logic [15:0] IMem_Data = 16'h0000;
    logic        IMem_Req;
    logic [15:0] IMem_Addr;
    logic [15:0] IFID_Instr;
    logic [15:0] IFID_PC;
    logic        IFID_Valid;
    logic        IDEX_Bubble;
    logic        Halted;
    logic [15:0] StallCount;

    logic        wRstN = 1'b0;
    logic [15:0] wData = 16'h0000;
    logic        wReq;
    logic [15:0] wAddr;
    logic [15:0] wInstr;
    logic [15:0] wPc;
    logic        wValid;
    logic        wBubble;
    logic        wHalted;
    logic [15:0] wStall;

    int    nTests = 0;
    int    nFail  = 0;
    vec_t  tbl[$];
    outs_t expQ[$];

    fetch_stall_sequencer dut (
        .clk(clk), .rst_n(rst_n), .PC_WriteEn(PC_WriteEn), .IFID_WriteEn(IFID_WriteEn),
        .Stall_flush(Stall_flush), .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .IMem_Ack(IMem_Ack), .IMem_Data(IMem_Data), .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
        .IFID_Instr(IFID_Instr), .IFID_PC(IFID_PC), .IFID_Valid(IFID_Valid),
        .IDEX_Bubble(IDEX_Bubble), .Halted(Halted), .StallCount(StallCount)
    );

    fetch_stall_sequencer #(.PC_RST(16'hFFFF)) dutWrap (
        .clk(clk), .rst_n(wRstN), .PC_WriteEn(1'b1), .IFID_WriteEn(1'b1),
        .Stall_flush(1'b0), .Branch_Taken(1'b0), .Branch_Target(16'h0000),
        .IMem_Ack(1'b1), .IMem_Data(wData), .IMem_Req(wReq), .IMem_Addr(wAddr),
        .IFID_Instr(wInstr), .IFID_PC(wPc), .IFID_Valid(wValid),
        .IDEX_Bubble(wBubble), .Halted(wHalted), .StallCount(wStall)
    );

    always #5 clk = ~clk;

    // Instruction memory: END opcode lives at address 5, everything else is 0x1000+addr.
    function automatic logic [15:0] memData(input logic [15:0] addr);
        if (addr == 16'd5) return 16'hE000;
        return 16'h1000 + addr;
    endfunction

    function automatic vec_t v(input logic rstN, pcWe, ifidWe, sf, br, input logic [15:0] tgt,
                               input logic ack, input logic req, input logic [15:0] addr,
                               input logic valid, input logic [15:0] pc, input logic [15:0] instr,
                               input logic bubble, input logic halted, input logic [15:0] stall);
        vec_t r;
        r.rstN = rstN; r.pcWe = pcWe; r.ifidWe = ifidWe; r.sf = sf; r.br = br;
        r.tgt = tgt; r.ack = ack;
        r.exp = '{req, addr, valid, pc, instr, bubble, halted, stall};
        return r;
    endfunction

    function automatic outs_t snap();
        return '{IMem_Req, IMem_Addr, IFID_Valid, IFID_PC, IFID_Instr, IDEX_Bubble, Halted, StallCount};
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("req=%0b addr=%h valid=%0b pc=%h instr=%h bubble=%0b halted=%0b stall=%h",
                         o.req, o.addr, o.valid, o.pc, o.instr, o.bubble, o.halted, o.stall);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        outs_t got;
        outs_t want;
        // rstN pcWe ifidWe sf br tgt ack | req addr valid pc instr bubble halted stall
        tbl.push_back(v(0,1,1,0,0,16'h0,1, 0,16'h0,0,16'h0,16'h0,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h0,0,16'h0,16'h0,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h1,1,16'h0,16'h1000,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h2,1,16'h1,16'h1001,0,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h3,1,16'h2,16'h1002,0,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h4,1,16'h3,16'h1003,0,0,16'd0));
        tbl.push_back(v(1,0,0,1,0,16'h0,1, 0,16'h4,1,16'h3,16'h1003,1,0,16'd1));
        tbl.push_back(v(1,0,0,1,0,16'h0,1, 0,16'h4,1,16'h3,16'h1003,1,0,16'd2));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h5,1,16'h4,16'h1004,0,0,16'd2));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h6,1,16'h5,16'hE000,0,0,16'd2));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 0,16'h6,1,16'h5,16'hE000,0,1,16'd2));
        tbl.push_back(v(1,1,1,0,1,16'h40,1, 0,16'h6,1,16'h5,16'hE000,1,1,16'd2));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 0,16'h6,1,16'h5,16'hE000,0,1,16'd2));
        tbl.push_back(v(0,1,1,0,0,16'h0,1, 0,16'h0,0,16'h0,16'h0,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,0, 1,16'h0,0,16'h0,16'h0,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h1,1,16'h0,16'h1000,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,1,16'h40,0, 1,16'h1,0,16'h0,16'h1000,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,0, 1,16'h1,0,16'h0,16'h1000,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,0, 1,16'h1,0,16'h0,16'h1000,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h40,0,16'h0,16'h1000,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h41,1,16'h40,16'h1040,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,0, 1,16'h41,0,16'h40,16'h1040,0,0,16'd0));
        tbl.push_back(v(1,1,1,0,1,16'h80,0, 1,16'h41,0,16'h40,16'h1040,1,0,16'd0));
        tbl.push_back(v(0,1,1,0,0,16'h0,1, 0,16'h0,0,16'h0,16'h0,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h0,0,16'h0,16'h0,1,0,16'd0));
        tbl.push_back(v(1,0,0,1,0,16'h0,1, 0,16'h0,0,16'h0,16'h0,1,0,16'd1));
        tbl.push_back(v(0,0,0,1,0,16'h0,1, 0,16'h0,0,16'h0,16'h0,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,0, 1,16'h0,0,16'h0,16'h0,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h1,1,16'h0,16'h1000,1,0,16'd0));
        tbl.push_back(v(1,1,0,0,0,16'h0,1, 0,16'h1,1,16'h0,16'h1000,0,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,0, 1,16'h2,1,16'h1,16'h1001,0,0,16'd0));
        tbl.push_back(v(1,0,0,0,0,16'h0,1, 0,16'h2,1,16'h1,16'h1001,0,0,16'd0));
        tbl.push_back(v(1,0,0,0,1,16'h10,0, 1,16'h10,0,16'h1,16'h1001,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h11,1,16'h10,16'h1010,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,1,16'h20,1, 1,16'h20,0,16'h10,16'h1010,1,0,16'd0));
        tbl.push_back(v(1,1,1,0,0,16'h0,1, 1,16'h21,1,16'h20,16'h1020,1,0,16'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n         = tbl[i].rstN;
            PC_WriteEn    = tbl[i].pcWe;
            IFID_WriteEn  = tbl[i].ifidWe;
            Stall_flush   = tbl[i].sf;
            Branch_Taken  = tbl[i].br;
            Branch_Target = tbl[i].tgt;
            IMem_Ack      = tbl[i].ack;
            IMem_Data     = memData(IMem_Addr);
            expQ.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            got  = snap();
            want = expQ.pop_front();
            nTests++;
            if (got !== want) begin
                nFail++;
                $display("FAIL vec%0d: got %s ; expected %s", i, fmt(got), fmt(want));
            end
        end

        // StallCount saturation under a long continuous stall.
        rst_n = 1'b0; Branch_Taken = 1'b0; IMem_Ack = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_reset", StallCount, 16'h0000);
        rst_n = 1'b1; Stall_flush = 1'b1; PC_WriteEn = 1'b0; IFID_WriteEn = 1'b0;
        for (int i = 1; i <= 70000; i++) begin
            @(posedge clk);
            #1;
            if (i == 65534) chk("stall_ffFE", StallCount, 16'hFFFE);
            if (i == 65535) chk("stall_ffFF", StallCount, 16'hFFFF);
        end
        chk("stall_saturated", StallCount, 16'hFFFF);
        chk("stall_bubble", {15'd0, IDEX_Bubble}, 16'h0001);
        Stall_flush = 1'b0;

        // PC wrap from all-ones to zero on the PC_RST=FFFF instance.
        wRstN = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap_rst_addr", wAddr, 16'hFFFF);
        chk("wrap_rst_req", {15'd0, wReq}, 16'h0000);
        wRstN = 1'b1;
        wData = memData(wAddr);
        @(posedge clk);
        #1;
        chk("wrap_req_addr", wAddr, 16'hFFFF);
        wData = memData(wAddr);
        @(posedge clk);
        #1;
        chk("wrap_ifid_pc", wPc, 16'hFFFF);
        chk("wrap_ifid_instr", wInstr, 16'h0FFF);
        chk("wrap_next_addr", wAddr, 16'h0000);
        wData = memData(wAddr);
        @(posedge clk);
        #1;
        chk("wrap_pc0", wPc, 16'h0000);
        chk("wrap_instr0", wInstr, 16'h1000);
        chk("wrap_addr1", wAddr, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
